// File: rtl/seven_segment_scan.sv
// rtl/seven_segment_scan.sv - time-multiplexed 7-segment scanner with frame-synchronous updates
module seven_segment_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int COMMON_ANODE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_tick
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic             POL      = (COMMON_ANODE != 0);

    localparam logic [6:0]            SEG_OFF = {7{POL}};
    localparam logic [NUM_DIGITS-1:0] EN_OFF  = {NUM_DIGITS{POL}};

    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        scan_idx;

    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_blank_lz;
    logic                    pend_valid;

    logic [4*NUM_DIGITS-1:0] act_data;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic                    act_blank_lz;

    logic                    div_wrap;
    logic                    frame_wrap;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   cur_onehot;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    upper_zero;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111100;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1100111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    assign div_wrap   = (div_cnt == DIV_LAST);
    assign frame_wrap = div_wrap && (scan_idx == IDX_LAST);

    // A digit is blanked when it and every more-significant nibble is zero; digit 0 always shows.
    always_comb begin
        lz_mask    = '0;
        upper_zero = act_blank_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (act_data[4*i +: 4] == 4'h0);
            lz_mask[i] = upper_zero;
        end
    end

    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_nib       = act_data[4*i +: 4];
                cur_dp        = act_dp[i];
                cur_blank     = lz_mask[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt       <= '0;
            scan_idx      <= '0;
            pend_data     <= '0;
            pend_dp       <= '0;
            pend_blank_lz <= 1'b0;
            pend_valid    <= 1'b0;
            act_data      <= '0;
            act_dp        <= '0;
            act_blank_lz  <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            if (div_wrap) begin
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
            end

            // Commit takes the pre-load pending value; a same-cycle load stays pending.
            if (frame_wrap && pend_valid) begin
                act_data     <= pend_data;
                act_dp       <= pend_dp;
                act_blank_lz <= pend_blank_lz;
            end

            if (load) begin
                pend_data     <= data_in;
                pend_dp       <= dp_in;
                pend_blank_lz <= blank_lz;
                pend_valid    <= 1'b1;
            end else if (frame_wrap) begin
                pend_valid    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg        <= SEG_OFF;
            dp         <= POL;
            digit_en   <= EN_OFF;
            frame_tick <= 1'b0;
        end else begin
            seg        <= (cur_blank ? 7'b0000000 : decode(cur_nib)) ^ SEG_OFF;
            dp         <= cur_dp ^ POL;
            // The first cycle of every slot is dark so the previous digit's segments never ghost.
            digit_en   <= ((div_cnt != '0) ? cur_onehot : '0) ^ EN_OFF;
            frame_tick <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
// tb/tb_seven_segment_scan.sv - directed self-checking bench for seven_segment_scan
module tb_seven_segment_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  digit_en;
    logic        frame_tick;
    logic [6:0]  ca_seg;
    logic        ca_dp;
    logic [3:0]  ca_digit_en;
    logic        ca_frame_tick;

    int checks = 0;
    int errors = 0;

    logic [6:0] dec_tab [0:10];

    always #5 clk = ~clk;

    seven_segment_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .COMMON_ANODE(0)) dut_cc (
        .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .seg(seg), .dp(dp), .digit_en(digit_en), .frame_tick(frame_tick)
    );

    seven_segment_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .COMMON_ANODE(1)) dut_ca (
        .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .seg(ca_seg), .dp(ca_dp), .digit_en(ca_digit_en),
        .frame_tick(ca_frame_tick)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        while (frame_tick !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk("frame_tick_seen", {31'b0, frame_tick}, 32'd1);
    endtask

    task automatic load_val(input logic [15:0] d, input logic [3:0] p, input logic b);
        data_in  = d;
        dp_in    = p;
        blank_lz = b;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    // Entered on the frame_tick cycle; leaves on the next frame_tick cycle.
    task automatic check_frame(input string tag, input logic [27:0] exp_seg, input logic [3:0] exp_dp);
        logic [6:0] es;
        logic [6:0] esn;
        logic [3:0] een;
        logic [3:0] eenn;
        for (int s = 0; s < 4; s++) begin
            tick();
            chk($sformatf("%s_gap%0d", tag, s), {28'b0, digit_en}, 32'd0);
            for (int k = 0; k < 3; k++) begin
                tick();
                es   = exp_seg[7*s +: 7];
                esn  = ~es;
                een  = 4'b0001 << s;
                eenn = ~een;
                chk($sformatf("%s_en%0d", tag, s), {28'b0, digit_en}, {28'b0, een});
                chk($sformatf("%s_seg%0d", tag, s), {25'b0, seg}, {25'b0, es});
                chk($sformatf("%s_dp%0d", tag, s), {31'b0, dp}, {31'b0, exp_dp[s]});
                chk($sformatf("%s_ca_seg%0d", tag, s), {25'b0, ca_seg}, {25'b0, esn});
                chk($sformatf("%s_ca_en%0d", tag, s), {28'b0, ca_digit_en}, {28'b0, eenn});
            end
        end
    endtask

    initial begin
        dec_tab[0]  = 7'b0111111;
        dec_tab[1]  = 7'b0000110;
        dec_tab[2]  = 7'b1011011;
        dec_tab[3]  = 7'b1001111;
        dec_tab[4]  = 7'b1100110;
        dec_tab[5]  = 7'b1101101;
        dec_tab[6]  = 7'b1111100;
        dec_tab[7]  = 7'b0000111;
        dec_tab[8]  = 7'b1111111;
        dec_tab[9]  = 7'b1100111;
        dec_tab[10] = 7'b1000000;

        reset    = 1'b1;
        data_in  = 16'h0;
        dp_in    = 4'h0;
        load     = 1'b0;
        blank_lz = 1'b0;

        // Reset levels for both polarities
        repeat (5) tick();
        chk("rst_seg", {25'b0, seg}, 32'h00);
        chk("rst_dp", {31'b0, dp}, 32'd0);
        chk("rst_en", {28'b0, digit_en}, 32'h0);
        chk("rst_tick", {31'b0, frame_tick}, 32'd0);
        chk("rst_ca_seg", {25'b0, ca_seg}, 32'h7f);
        chk("rst_ca_dp", {31'b0, ca_dp}, 32'd1);
        chk("rst_ca_en", {28'b0, ca_digit_en}, 32'hf);
        chk("rst_ca_tick", {31'b0, ca_frame_tick}, 32'd0);
        reset = 1'b0;

        // Scan order and decimal point
        load_val(16'h1234, 4'b0100, 1'b0);
        wait_frame();
        check_frame("scan", {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110}, 4'b0100);

        // Decode sweep on digit 0, upper digits show zero
        for (int v = 0; v <= 10; v++) begin
            load_val(16'(v), 4'b0000, 1'b0);
            wait_frame();
            check_frame($sformatf("dec%0d", v),
                        {7'b0111111, 7'b0111111, 7'b0111111, dec_tab[v]}, 4'b0000);
        end

        // Leading-zero blanking
        load_val(16'h0007, 4'b0000, 1'b1);
        wait_frame();
        check_frame("lz7", {7'b0, 7'b0, 7'b0, 7'b0000111}, 4'b0000);
        load_val(16'h0000, 4'b0000, 1'b1);
        wait_frame();
        check_frame("lz0", {7'b0, 7'b0, 7'b0, 7'b0111111}, 4'b0000);
        load_val(16'h0100, 4'b0000, 1'b1);
        wait_frame();
        check_frame("lz100", {7'b0, 7'b0000110, 7'b0111111, 7'b0111111}, 4'b0000);

        // Mid-frame loads: last wins, current frame untouched
        repeat (3) tick();
        load_val(16'h1111, 4'b0000, 1'b0);
        tick();
        load_val(16'h2222, 4'b0000, 1'b0);
        repeat (4) tick();
        chk("old_frame_en", {28'b0, digit_en}, 32'h4);
        chk("old_frame_seg", {25'b0, seg}, {25'b0, 7'b0000110});
        repeat (5) tick();
        chk("pre_commit_tick", {31'b0, frame_tick}, 32'd0);
        data_in = 16'h3333;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        chk("commit_tick", {31'b0, frame_tick}, 32'd1);
        check_frame("upd2222", {4{7'b1011011}}, 4'b0000);
        check_frame("upd3333", {4{7'b1001111}}, 4'b0000);

        // Reset in slot 2 with data pending
        load_val(16'h5678, 4'b0000, 1'b0);
        wait_frame();
        load_val(16'h9999, 4'b0000, 1'b0);
        repeat (9) tick();
        chk("pre_rst_en", {28'b0, digit_en}, 32'h4);
        chk("pre_rst_seg", {25'b0, seg}, {25'b0, 7'b1111100});
        reset = 1'b1;
        tick();
        chk("mid_rst_seg", {25'b0, seg}, 32'h00);
        chk("mid_rst_dp", {31'b0, dp}, 32'd0);
        chk("mid_rst_en", {28'b0, digit_en}, 32'h0);
        chk("mid_rst_tick", {31'b0, frame_tick}, 32'd0);
        chk("mid_rst_ca_seg", {25'b0, ca_seg}, 32'h7f);
        chk("mid_rst_ca_en", {28'b0, ca_digit_en}, 32'hf);
        chk("mid_rst_ca_dp", {31'b0, ca_dp}, 32'd1);
        repeat (2) tick();
        chk("mid_rst_tick_hold", {31'b0, frame_tick}, 32'd0);
        reset = 1'b0;
        wait_frame();
        check_frame("post_rst", {4{7'b0111111}}, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
